bcd_sub_display_scan: RTL
=========================

Name: bcd_sub_display_scan

Overview:
- Downstream consumer of the BCD subtractor stage: accepts one result (operands A, B, magnitude, sign) through a valid/ready handshake.
- Drives a 4-digit multiplexed, common-anode seven-segment display (active-low anodes and cathodes).
- Holds the last accepted result and refreshes the digits continuously.
- New results are swapped in only at frame boundaries, so a frame never shows digits from two different results.

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot. Must be >= 2. Gives 1 kHz digit rate at 100 MHz; use 4 in simulation.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  result presented this cycle
- in_ready  out  1  block can capture a result
- a  in  4  minuend digit
- b  in  4  subtrahend digit
- diff  in  4  magnitude |a-b|
- neg  in  1  1 = result negative (a<b)
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low; tied off (1)
- an  out  4  digit anodes, active-low, one-hot-low when active

Behaviour:
- Reset is asynchronous assert, synchronous release. On reset:
  - prescaler=0, digit index=0, pending_valid=0
  - display register {a,b,diff,neg}=0
  - an=4'b1111, seg=7'b1111111, dp=1, in_ready=1
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 in the cycle where count==CLK_DIV-1.
- Digit index:
  - 2-bit, increments on tick, wraps 3->0.
  - frame_boundary = tick && index==3.
- Output registers: seg/an update in the cycle after tick (one-cycle latency), from the new index.
  - idx0: an=1110, seg=decode(diff)
  - idx1: an=1101, seg = 0111111 ('-') if neg, else 1111111 (blank)
  - idx2: an=1011, seg=decode(b)
  - idx3: an=0111, seg=decode(a)
  - Before the first tick after reset, all digits stay off.
- Digit decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10..15 shows 'E' = 0000110 (invalid BCD).
- Handshake:
  - in_ready = !pending_valid (registered state, no combinational path from in_valid).
  - Transfer occurs when in_valid && in_ready: capture {a,b,diff,neg} into the pending register and set pending_valid=1.
  - When in_valid is high and in_ready low, inputs are ignored. The upstream stage must hold them until accepted.
- Frame swap:
  - On frame_boundary with pending_valid=1: display register <= pending, pending_valid <= 0.
  - in_ready rises the next cycle.
  - The new value first appears on idx0, one cycle after the boundary tick.
- Simultaneous events:
  - Transfer in the same cycle as frame_boundary while pending is empty: the data goes to pending and is not swapped in that cycle. It is displayed at the following boundary.
  - Transfer cannot coincide with a swap, because a swap requires pending_valid=1, which forces in_ready=0.
- Consistency is not checked: diff/neg are displayed as given, with no check against a and b.
- Reset mid-frame or mid-handshake:
  - All state is cleared immediately and the pending result is discarded.
  - Display blanks until the first post-reset tick, then shows 0,blank,0,0.

Decomposition:
- Package bcd_disp_pkg holds:
  - Segment constants SEG_0..SEG_9, SEG_MINUS, SEG_BLANK, SEG_E (7-bit, active-low)
  - Anode constants AN_OFF, AN_D0..AN_D3
- Sub-module bcd_to_seg: combinational, 4-bit digit in, 7-bit active-low segments out, 'E' for 10..15. Instantiated once, fed by a 4:1 digit mux.
- Top contains the prescaler, index counter, pending/display registers, handshake and output registers.

Test Plan (CLK_DIV=4):
- Reset then idle 20 cycles -> an=1111 and seg=1111111 until first tick at cycle 3; then an cycles 1110,1101,1011,0111 every 4 clocks with seg 1000000,1111111,1000000,1000000; in_ready=1 throughout.
- Send a=7,b=3,diff=4,neg=0 mid-frame -> in_ready=0 next cycle; old digits for the rest of the frame; after the boundary, idx0 seg=0011001, idx1 blank, idx2 0110000, idx3 1111000; in_ready=1 one cycle after the boundary.
- Send a=2,b=9,diff=7,neg=1 -> idx1 seg=0111111, idx0 seg=1111000.
- Send a second result while pending_valid=1 (in_valid held) -> not captured until in_ready rises; the first result shows for one full frame, then the second.
- Send diff=12 (invalid) -> idx0 seg=0000110.
- Assert rst_n low for 2 cycles while pending_valid=1 and idx=2 -> outputs go to the reset values asynchronously; the pending result is never displayed.

Source files
------------

// File: rtl/bcd_sub_display_scan_pkg.sv
// Shared constants and types for the BCD subtractor display scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low; anodes are active-low.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] AN_D0  = 4'b1110;
  localparam logic [3:0] AN_D1  = 4'b1101;
  localparam logic [3:0] AN_D2  = 4'b1011;
  localparam logic [3:0] AN_D3  = 4'b0111;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] diff;
    logic       neg;
  } result_t;

endpackage

// File: rtl/bcd_sub_display_scan_if.sv
// Valid/ready result channel from the BCD subtractor into the display scanner.
interface bcd_sub_display_scan_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] diff;
  logic       neg;

  modport master (output in_valid, a, b, diff, neg, input in_ready);
  modport slave  (input in_valid, a, b, diff, neg, output in_ready);
endinterface

// File: rtl/bcd_sub_display_scan_bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-BCD codes (10..15) render as 'E'.
module bcd_to_seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_E;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end
endmodule

// File: rtl/bcd_sub_display_scan.sv
// Accepts BCD subtraction results and scans them onto a 4-digit common-anode
// display; new results are swapped in only at frame boundaries.
module bcd_sub_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bcd_sub_display_scan_if.slave   up,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [3:0]              an
);
  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    nidx;
  logic          tick;
  logic          frame_boundary;
  logic          pend_valid;
  result_t       pend;
  result_t       disp;
  result_t       src;
  logic [3:0]    digit;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;

  assign tick           = (cnt == CW'(CLK_DIV - 1));
  assign frame_boundary = tick && (idx == 2'd3);
  assign nidx           = idx + 2'd1;
  assign up.in_ready    = !pend_valid;
  assign dp             = 1'b1;

  // The swap and the idx0 output load share the boundary edge, so read the
  // incoming result directly to avoid showing one stale digit.
  assign src = (frame_boundary && pend_valid) ? pend : disp;

  always_comb begin
    digit   = src.diff;
    an_next = AN_D0;
    case (nidx)
      2'd0: begin digit = src.diff; an_next = AN_D0; end
      2'd1: begin digit = src.diff; an_next = AN_D1; end
      2'd2: begin digit = src.b;    an_next = AN_D2; end
      2'd3: begin digit = src.a;    an_next = AN_D3; end
      default: begin digit = src.diff; an_next = AN_D0; end
    endcase
  end

  bcd_to_seg u_dec (
    .digit (digit),
    .seg   (dec_seg)
  );

  always_comb begin
    seg_next = dec_seg;
    if (nidx == 2'd1) seg_next = src.neg ? SEG_MINUS : SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      an         <= AN_OFF;
      seg        <= SEG_BLANK;
      pend_valid <= 1'b0;
      pend       <= '0;
      disp       <= '0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) begin
        idx <= nidx;
        an  <= an_next;
        seg <= seg_next;
      end
      // Capture and swap are mutually exclusive: a swap needs pend_valid=1,
      // which holds in_ready low.
      if (up.in_valid && !pend_valid) begin
        pend       <= '{a: up.a, b: up.b, diff: up.diff, neg: up.neg};
        pend_valid <= 1'b1;
      end else if (frame_boundary && pend_valid) begin
        disp       <= pend;
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
